// File: rtl/mux_truth_table_unit_pkg.sv
// ---------------------------------------------------------------------------
// mux_truth_table_unit_pkg
// Shared constants and types for the mux truth-table lab block:
//   - F3 constant legs (LEG0 / LEG3)
//   - bit positions of the A/B/C inputs inside each input group
//   - the packed output register bank type used by the top level
// ---------------------------------------------------------------------------
package mux_truth_table_unit_pkg;

  // F3 constant mux legs.
  localparam logic LEG0 = 1'b0;
  localparam logic LEG3 = 1'b1;

  // F1 / F2 two-bit groups (d0, d1): {B, C}.
  localparam int unsigned GRP2_B = 1;
  localparam int unsigned GRP2_C = 0;

  // F3 three-bit group (d2): {A, B, C}.
  localparam int unsigned GRP3_A = 2;
  localparam int unsigned GRP3_B = 1;
  localparam int unsigned GRP3_C = 0;

  // Complete registered output image of the block.
  typedef struct packed {
    logic [1:0] y2;    // F1 legs {leg1, leg0}
    logic       y3;    // F1 result
    logic [1:0] y4;    // F2 legs {leg1, leg0}
    logic       y5;    // F2 result
    logic [1:0] y6;    // F3 select {A, B}
    logic [3:0] y100;  // F3 legs {leg3, leg2, leg1, leg0}
    logic       y7;    // F3 result
  } out_bank_t;

endpackage : mux_truth_table_unit_pkg

// File: rtl/mux_truth_table_unit_mux4_cell.sv
// ---------------------------------------------------------------------------
// mux4_cell
// Generic purely combinational 4:1 multiplexer, one bit wide.
// Ports:
//   data [3:0] in  : data legs, data[i] selected when sel == i
//   sel  [1:0] in  : leg select
//   y          out : selected leg
// ---------------------------------------------------------------------------
module mux4_cell (
  input  logic [3:0] data,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = data[sel];

endmodule : mux4_cell

// File: rtl/mux_truth_table_unit.sv
// ---------------------------------------------------------------------------
// mux_truth_table_unit
// Three independent fixed 3-input Boolean functions, each realised as a mux
// selected by its high-order input(s), with every result and debug leg
// registered (latency 1 cycle, one evaluation per cycle per function).
//   F1: odd parity  A^B^C         (2:1 mux on A)
//   F2: majority    AB+AC+BC      (2:1 mux on A)
//   F3: 4:1 mux on {A,B}, legs {1, ~C, C, 0}
// Ports:
//   clk        in  : rising-edge clock
//   reset      in  : synchronous active-high, clears all outputs
//   t          in  : F1 A
//   d0   [1:0] in  : F1 {B, C}
//   u          in  : F2 A
//   d1   [1:0] in  : F2 {B, C}
//   d2   [2:0] in  : F3 {A, B, C}
//   y2   [1:0] out : F1 legs {leg1, leg0}
//   y3         out : F1 result
//   y4   [1:0] out : F2 legs {leg1, leg0}
//   y5         out : F2 result
//   y6   [1:0] out : F3 select {A, B}
//   y100 [3:0] out : F3 legs, y100[i] = leg i
//   y7         out : F3 result
// ---------------------------------------------------------------------------
module mux_truth_table_unit
  import mux_truth_table_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       t,
  input  logic [1:0] d0,
  input  logic       u,
  input  logic [1:0] d1,
  input  logic [2:0] d2,
  output logic [1:0] y2,
  output logic       y3,
  output logic [1:0] y4,
  output logic       y5,
  output logic [1:0] y6,
  output logic [3:0] y100,
  output logic       y7
);

  // Leg generation.
  logic [1:0] f1_legs;
  logic [1:0] f2_legs;
  logic [1:0] f3_sel;
  logic [3:0] f3_legs;
  logic       f1_y;
  logic       f2_y;
  logic       f3_y;

  always_comb begin
    f1_legs[0] = d0[GRP2_B] ^ d0[GRP2_C];
    f1_legs[1] = ~(d0[GRP2_B] ^ d0[GRP2_C]);
    f2_legs[0] = d1[GRP2_B] & d1[GRP2_C];
    f2_legs[1] = d1[GRP2_B] | d1[GRP2_C];
    f3_sel     = {d2[GRP3_A], d2[GRP3_B]};
    f3_legs    = {LEG3, ~d2[GRP3_C], d2[GRP3_C], LEG0};
  end

  // F1 and F2 only need a 2:1 mux: the upper select bit is tied low so only
  // legs 0/1 are reachable, and the unused upper legs are tied to 0.
  mux4_cell u_f1_mux (
    .data ({2'b00, f1_legs}),
    .sel  ({1'b0, t}),
    .y    (f1_y)
  );

  mux4_cell u_f2_mux (
    .data ({2'b00, f2_legs}),
    .sel  ({1'b0, u}),
    .y    (f2_y)
  );

  mux4_cell u_f3_mux (
    .data (f3_legs),
    .sel  (f3_sel),
    .y    (f3_y)
  );

  // Output register bank.
  out_bank_t out_d;
  out_bank_t out_q;

  // NOTE: every field is assigned on every pass through this block, starting
  // from a full default, so no latch can be inferred.
  always_comb begin
    out_d      = '0;
    out_d.y2   = f1_legs;
    out_d.y3   = f1_y;
    out_d.y4   = f2_legs;
    out_d.y5   = f2_y;
    out_d.y6   = f3_sel;
    out_d.y100 = f3_legs;
    out_d.y7   = f3_y;
  end

  // NOTE: state registers use non-blocking assignment so all flops update
  // together from pre-edge values; reset wins over loading new inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign y2   = out_q.y2;
  assign y3   = out_q.y3;
  assign y4   = out_q.y4;
  assign y5   = out_q.y5;
  assign y6   = out_q.y6;
  assign y100 = out_q.y100;
  assign y7   = out_q.y7;

endmodule : mux_truth_table_unit

// File: tb/tb_mux_truth_table_unit.sv
// ---------------------------------------------------------------------------
// tb_mux_truth_table_unit
// Self-checking bench: directed sweeps plus random stimulus, compared each
// cycle against an arithmetic reference model of the three functions.
// ---------------------------------------------------------------------------
module tb_mux_truth_table_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       t;
  logic [1:0] d0;
  logic       u;
  logic [1:0] d1;
  logic [2:0] d2;
  logic [1:0] y2;
  logic       y3;
  logic [1:0] y4;
  logic       y5;
  logic [1:0] y6;
  logic [3:0] y100;
  logic       y7;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_truth_table_unit dut (
    .clk  (clk),
    .reset(reset),
    .t    (t),
    .d0   (d0),
    .u    (u),
    .d1   (d1),
    .d2   (d2),
    .y2   (y2),
    .y3   (y3),
    .y4   (y4),
    .y5   (y5),
    .y6   (y6),
    .y100 (y100),
    .y7   (y7)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model from the function definitions, using plain arithmetic.
  // Result packed as {y2, y3, y4, y5, y6, y100, y7}.
  function automatic logic [12:0] model(input bit rst, input int a1, input int b1,
                                        input int c1, input int a2, input int b2,
                                        input int c2, input int a3, input int b3,
                                        input int c3);
    logic [7:0] f3_tt;
    int f1_l0, f1_l1, f2_l0, f2_l1, f1, f2, f3;
    logic [3:0] f3_legs;
    if (rst) return '0;
    f1_l0   = (b1 + c1) % 2;
    f1_l1   = 1 - f1_l0;
    f1      = (a1 + b1 + c1) % 2;
    f2_l0   = b2 * c2;
    f2_l1   = (b2 + c2 > 0) ? 1 : 0;
    f2      = (a2 + b2 + c2 >= 2) ? 1 : 0;
    f3_tt   = 8'b1101_1000;            // bit i = Y for ABC = i
    f3      = f3_tt[a3 * 4 + b3 * 2 + c3];
    f3_legs = {1'b1, 1'(1 - c3), 1'(c3), 1'b0};
    return {2'(f1_l1 * 2 + f1_l0), 1'(f1), 2'(f2_l1 * 2 + f2_l0), 1'(f2),
            2'(a3 * 2 + b3), f3_legs, 1'(f3)};
  endfunction

  // Apply inputs and reset for one edge, then compare all outputs.
  task automatic step(input bit rst, input logic [2:0] g1, input logic [2:0] g2,
                      input logic [2:0] g3, input string tag);
    logic [12:0] exp_v;
    reset = rst;
    t  = g1[2];
    d0 = g1[1:0];
    u  = g2[2];
    d1 = g2[1:0];
    d2 = g3;
    exp_v = model(rst, int'(g1[2]), int'(g1[1]), int'(g1[0]), int'(g2[2]),
                  int'(g2[1]), int'(g2[0]), int'(g3[2]), int'(g3[1]), int'(g3[0]));
    @(posedge clk);
    #1;
    check({tag, ".y2"},   32'(y2),   32'(exp_v[12:11]));
    check({tag, ".y3"},   32'(y3),   32'(exp_v[10]));
    check({tag, ".y4"},   32'(y4),   32'(exp_v[9:8]));
    check({tag, ".y5"},   32'(y5),   32'(exp_v[7]));
    check({tag, ".y6"},   32'(y6),   32'(exp_v[6:5]));
    check({tag, ".y100"}, 32'(y100), 32'(exp_v[4:1]));
    check({tag, ".y7"},   32'(y7),   32'(exp_v[0]));
  endtask

  initial begin
    logic [2:0] r1, r2;
    logic [7:0] f1_exp, f2_exp, f3_exp;
    f1_exp = 8'b1001_0110;  // ABC=000..111 -> 0,1,1,0,1,0,0,1
    f2_exp = 8'b1110_1000;  // 0,0,0,1,0,1,1,1
    f3_exp = 8'b1101_1000;  // 0,0,0,1,1,0,1,1

    // Reset with all inputs high, then release.
    step(1'b1, 3'b111, 3'b111, 3'b111, "rst0");
    step(1'b1, 3'b111, 3'b111, 3'b111, "rst1");
    step(1'b0, 3'b111, 3'b111, 3'b111, "rel");
    check("rel.y100_lit", 32'(y100), 32'h0000_000A);

    // F1 sweep with a one-cycle reset at ABC=011, then resume.
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step(1'b1, 3'(i), 3'b000, 3'b000, "f1_rst");
      step(1'b0, 3'(i), 3'b000, 3'b000, "f1");
      check("f1.tt", 32'(y3), 32'(f1_exp[i]));
      if (i == 5) check("f1.y2_101", 32'(y2), 32'h1);
    end

    // F2 sweep.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b000, 3'(i), 3'b000, "f2");
      check("f2.tt", 32'(y5), 32'(f2_exp[i]));
      if (i == 2) check("f2.y4_010", 32'(y4), 32'h2);
    end

    // F3 sweep.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 3'b000, 3'b000, 3'(i), "f3");
      check("f3.tt", 32'(y7), 32'(f3_exp[i]));
    end

    // Independence: hold F3 group, randomise F1/F2 groups.
    for (int i = 0; i < 20; i++) begin
      r1 = 3'($urandom_range(7));
      r2 = 3'($urandom_range(7));
      step(1'b0, r1, r2, 3'b011, "indep");
      check("indep.y7", 32'(y7), 32'h1);
      check("indep.y6", 32'(y6), 32'h1);
    end

    // Fully random stimulus with occasional reset.
    for (int i = 0; i < 100; i++) begin
      step(($urandom_range(15) == 0), 3'($urandom_range(7)), 3'($urandom_range(7)),
           3'($urandom_range(7)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mux_truth_table_unit
